// File: rtl/window_fetch.sv
// ---------------------------------------------------------------------------
// window_fetch
// Producer side of the CNN ALU datapath. Loads the 3x3 filter taps (conv
// only) and then walks a window across the image in raster order. For each
// origin it reads the pixels the mode needs and packs them into I_out. The
// window is then held under a valid/ready handshake until the ALU accepts it.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, mode       frame start pulse; mode 0=conv 1=relu 2=pool 3=relu
//   img_addr/img_rd   image memory read port, data on img_data one cycle later
//   fil_addr/fil_rd   filter memory read port, data on fil_data one cycle later
//   I_out             10 window lanes, lane k at I_out[k*N +: N]
//   F_out             9 filter taps, tap k at F_out[k*N +: N]
//   out_valid         window complete; accepted on out_valid && out_ready
//   busy              frame in progress
//   done              one-cycle pulse after the last window is accepted
// ---------------------------------------------------------------------------
module window_fetch #(
    parameter int unsigned N    = 8,
    parameter int unsigned M_AW = 10,
    parameter int unsigned F_AW = 4,
    parameter int unsigned FIL  = 3,
    parameter int unsigned IMG  = 28,
    parameter int unsigned IOUT = 10 * N,
    parameter int unsigned FOUT = 9 * N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    output logic [M_AW-1:0] img_addr,
    output logic            img_rd,
    input  logic [N-1:0]    img_data,
    output logic [F_AW-1:0] fil_addr,
    output logic            fil_rd,
    input  logic [N-1:0]    fil_data,
    output logic [IOUT-1:0] I_out,
    output logic [FOUT-1:0] F_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW    = $clog2(IMG);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TAPS  = FIL * FIL;

    // Last legal window origin per mode (pool steps by two)
    localparam logic [CW-1:0] LIM_CONV = CW'(IMG - FIL);
    localparam logic [CW-1:0] LIM_RELU = CW'(IMG - 1);
    localparam logic [CW-1:0] LIM_POOL = CW'(((IMG - 2) / 2) * 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_F,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONV = 2'd0,
        MODE_RELU = 2'd1,
        MODE_POOL = 2'd2
    } mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic [M_AW-1:0]   img_addr_q, img_addr_d;
    logic              img_rd_q, img_rd_d;
    logic [F_AW-1:0]   fil_addr_q, fil_addr_d;
    logic              fil_rd_q, fil_rd_d;
    logic [IOUT-1:0]   iout_q, iout_d;
    logic [FOUT-1:0]   fout_q, fout_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Window stepping helpers
    logic [CW-1:0]     stride, lim, nr, nc;
    logic [CW:0]       c_sum;
    logic              last_win;
    logic [CNT_W-1:0]  len;

    // Reads per window
    function automatic logic [CNT_W-1:0] rd_len(input mode_e m);
        case (m)
            MODE_CONV: rd_len = CNT_W'(TAPS);
            MODE_POOL: rd_len = CNT_W'(4);
            default:   rd_len = CNT_W'(1);
        endcase
    endfunction

    // Destination lane of read idx; pool's fourth read lands on lane 9
    function automatic logic [CNT_W-1:0] rd_lane(input mode_e m, input logic [CNT_W-1:0] idx);
        case (m)
            MODE_CONV: rd_lane = idx;
            MODE_POOL: rd_lane = (idx == CNT_W'(3)) ? CNT_W'(9) : idx;
            default:   rd_lane = '0;
        endcase
    endfunction

    // Row offset of read idx within the window
    function automatic logic [CW-1:0] rd_di(input mode_e m, input logic [CNT_W-1:0] idx);
        case (m)
            MODE_CONV: rd_di = CW'(32'(idx) / FIL);
            MODE_POOL: rd_di = CW'(idx[1]);
            default:   rd_di = '0;
        endcase
    endfunction

    // Column offset of read idx within the window
    function automatic logic [CW-1:0] rd_dj(input mode_e m, input logic [CNT_W-1:0] idx);
        case (m)
            MODE_CONV: rd_dj = CW'(32'(idx) % FIL);
            MODE_POOL: rd_dj = CW'(idx[0]);
            default:   rd_dj = '0;
        endcase
    endfunction

    function automatic logic [M_AW-1:0] pix_addr(input logic [CW-1:0] r, c, di, dj);
        int unsigned row, col;
        row = 32'(r) + 32'(di);
        col = 32'(c) + 32'(dj);
        pix_addr = M_AW'(row * IMG + col);
    endfunction

    // Next origin in raster order and last-window detection
    always_comb begin
        stride   = (mode_q == MODE_POOL) ? CW'(2) : CW'(1);
        case (mode_q)
            MODE_CONV: lim = LIM_CONV;
            MODE_POOL: lim = LIM_POOL;
            default:   lim = LIM_RELU;
        endcase
        len      = rd_len(mode_q);
        last_win = (r_q == lim) && (c_q == lim);
        c_sum    = (CW+1)'(c_q) + (CW+1)'(stride);
        if (c_sum > (CW+1)'(lim)) begin
            nc = '0;
            nr = r_q + stride;
        end else begin
            nc = CW'(c_sum);
            nr = r_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_CONV;
            cnt_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            img_addr_q  <= '0;
            img_rd_q    <= 1'b0;
            fil_addr_q  <= '0;
            fil_rd_q    <= 1'b0;
            iout_q      <= '0;
            fout_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            img_addr_q  <= img_addr_d;
            img_rd_q    <= img_rd_d;
            fil_addr_q  <= fil_addr_d;
            fil_rd_q    <= fil_rd_d;
            iout_q      <= iout_d;
            fout_q      <= fout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        img_addr_d  = img_addr_q;
        img_rd_d    = 1'b0;
        fil_addr_d  = fil_addr_q;
        fil_rd_d    = 1'b0;
        iout_d      = iout_q;
        fout_d      = fout_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    r_d    = '0;
                    c_d    = '0;
                    cnt_d  = '0;
                    mode_d = (mode == 2'd3) ? MODE_RELU : mode_e'(mode);
                    if (mode == 2'd0) begin
                        state_d    = S_LOAD_F;
                        fil_rd_d   = 1'b1;
                        fil_addr_d = '0;
                    end else begin
                        state_d    = S_FETCH;
                        img_rd_d   = 1'b1;
                        img_addr_d = pix_addr('0, '0, '0, '0);
                    end
                end
            end

            S_LOAD_F: begin
                // Tap read at cnt-1 arrives now
                if (cnt_q != '0) begin
                    fout_d[(32'(cnt_q) - 32'd1) * N +: N] = fil_data;
                end
                if (cnt_q == CNT_W'(TAPS)) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    img_rd_d   = 1'b1;
                    img_addr_d = pix_addr(r_q, c_q, '0, '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (32'(cnt_q) < TAPS - 1) begin
                        fil_rd_d   = 1'b1;
                        fil_addr_d = F_AW'(cnt_q + CNT_W'(1));
                    end
                end
            end

            S_FETCH: begin
                // Clear on entry so lanes the mode does not use read as zero
                if (cnt_q == '0) begin
                    iout_d = '0;
                end else begin
                    iout_d[32'(rd_lane(mode_q, cnt_q - CNT_W'(1))) * N +: N] = img_data;
                end
                if (cnt_q == len) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((cnt_q + CNT_W'(1)) < len) begin
                        img_rd_d   = 1'b1;
                        img_addr_d = pix_addr(r_q, c_q,
                                              rd_di(mode_q, cnt_q + CNT_W'(1)),
                                              rd_dj(mode_q, cnt_q + CNT_W'(1)));
                    end
                end
            end

            S_HOLD: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_win) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_FETCH;
                        r_d        = nr;
                        c_d        = nc;
                        cnt_d      = '0;
                        img_rd_d   = 1'b1;
                        img_addr_d = pix_addr(nr, nc, '0, '0);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign img_addr  = img_addr_q;
    assign img_rd    = img_rd_q;
    assign fil_addr  = fil_addr_q;
    assign fil_rd    = fil_rd_q;
    assign I_out     = iout_q;
    assign F_out     = fout_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
